// File: rtl/fp_addsub_seq.sv
// Sequential add/subtract for an 11-bit float {sign, exp[3:0], mant[5:0]}. Optional rounding: FP_ADDSUB_ROUND_EN.
// Latency: done rises 3+d+n edges after start is sampled (d = align shifts, n = norm shifts), +1 with rounding.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy, result is held until the next op.
`timescale 1ns/1ps
module fp_addsub_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic        busy,
  output logic        done,
  output logic [10:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ALIGN  = 3'd1;
  localparam logic [2:0] S_ADDSUB = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
`ifdef FP_ADDSUB_ROUND_EN
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_POST_NORM = S_ROUND;
`else
  localparam logic [2:0] S_POST_NORM = 3'd5;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        big_sign_q, big_sign_d;   // operand sign, later the working result sign
  logic [3:0]  big_exp_q, big_exp_d;     // operand exponent, later the working result exponent
  logic [5:0]  big_mant_q, big_mant_d;
  logic [5:0]  small_mant_q, small_mant_d;
  logic        eff_sub_q, eff_sub_d;
  logic [3:0]  diff_q, diff_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sum_q, sum_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [10:0] result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
`ifdef FP_ADDSUB_ROUND_EN
  logic        guard_q, guard_d;
  logic [6:0]  round_sum;
`endif

  // Operand steering at capture: B carries its effective sign, larger {exp,mant} becomes "big".
  logic       b_eff_sign;
  logic       a_is_big;
  assign b_eff_sign = b[10] ^ op;
  assign a_is_big   = (a[9:0] >= b[9:0]);

  // Next-state and datapath for the whole sequence.
  always_comb begin
    state_d      = state_q;
    big_sign_d   = big_sign_q;
    big_exp_d    = big_exp_q;
    big_mant_d   = big_mant_q;
    small_mant_d = small_mant_q;
    eff_sub_d    = eff_sub_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    result_d     = result_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
`ifdef FP_ADDSUB_ROUND_EN
    guard_d      = guard_q;
    round_sum    = sum_q + 7'd1;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          big_sign_d   = a_is_big ? a[10]   : b_eff_sign;
          big_exp_d    = a_is_big ? a[9:6]  : b[9:6];
          big_mant_d   = a_is_big ? a[5:0]  : b[5:0];
          small_mant_d = a_is_big ? b[5:0]  : a[5:0];
          diff_d       = a_is_big ? (a[9:6] - b[9:6]) : (b[9:6] - a[9:6]);
          eff_sub_d    = (a[10] != b_eff_sign);
          cnt_d        = 3'd0;
          ovf_d        = 1'b0;
          unf_d        = 1'b0;
          overflow_d   = 1'b0;
          underflow_d  = 1'b0;
`ifdef FP_ADDSUB_ROUND_EN
          guard_d      = 1'b0;
`endif
          state_d      = S_ALIGN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_ALIGN: begin
        // One bit per cycle; six shifts already empty the 6-bit mantissa.
        if (({1'b0, cnt_q} == diff_q) || (cnt_q == 3'd6)) begin
          state_d = S_ADDSUB;
        end else begin
          small_mant_d = {1'b0, small_mant_q[5:1]};
          cnt_d        = cnt_q + 3'd1;
`ifdef FP_ADDSUB_ROUND_EN
          guard_d      = small_mant_q[0];
`endif
        end
      end

      S_ADDSUB: begin
        if (eff_sub_q) sum_d = {1'b0, big_mant_q} - {1'b0, small_mant_q};
        else           sum_d = {1'b0, big_mant_q} + {1'b0, small_mant_q};
        state_d = S_NORM;
      end

      S_NORM: begin
        if (sum_q[6]) begin
          if (big_exp_q == 4'hF) begin
            ovf_d     = 1'b1;
            sum_d     = 7'h3F;
            state_d   = S_POST_NORM;
          end else begin
            sum_d     = {1'b0, sum_q[6:1]};
            big_exp_d = big_exp_q + 4'd1;
`ifdef FP_ADDSUB_ROUND_EN
            guard_d   = sum_q[0];
`endif
          end
        end else if (sum_q == 7'd0) begin
          // Exact cancellation always yields +0.
          big_sign_d = 1'b0;
          big_exp_d  = 4'd0;
          state_d    = S_POST_NORM;
        end else if (!sum_q[5]) begin
          if (big_exp_q == 4'd0) begin
            unf_d      = 1'b1;
            big_sign_d = 1'b0;
            sum_d      = 7'd0;
            state_d    = S_POST_NORM;
          end else begin
            sum_d     = {sum_q[5:0], 1'b0};
            big_exp_d = big_exp_q - 4'd1;
          end
        end else begin
          state_d = S_POST_NORM;
        end
      end

`ifdef FP_ADDSUB_ROUND_EN
      S_ROUND: begin
        // Round half up; saturated, flushed and zero results are left alone.
        if (!ovf_q && !unf_q && (sum_q != 7'd0) && guard_q) begin
          if (round_sum[6]) begin
            if (big_exp_q == 4'hF) begin
              ovf_d = 1'b1;
              sum_d = 7'h3F;
            end else begin
              sum_d     = 7'h20;
              big_exp_d = big_exp_q + 4'd1;
            end
          end else begin
            sum_d = round_sum;
          end
        end
        state_d = S_DONE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Visible result and flags change only on the way into DONE.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      result_d    = {big_sign_d, big_exp_d, sum_d[5:0]};
      overflow_d  = ovf_d;
      underflow_d = unf_d;
    end
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      big_sign_q   <= 1'b0;
      big_exp_q    <= 4'd0;
      big_mant_q   <= 6'd0;
      small_mant_q <= 6'd0;
      eff_sub_q    <= 1'b0;
      diff_q       <= 4'd0;
      cnt_q        <= 3'd0;
      sum_q        <= 7'd0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      result_q     <= 11'd0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
`ifdef FP_ADDSUB_ROUND_EN
      guard_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      big_sign_q   <= big_sign_d;
      big_exp_q    <= big_exp_d;
      big_mant_q   <= big_mant_d;
      small_mant_q <= small_mant_d;
      eff_sub_q    <= eff_sub_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      result_q     <= result_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
`ifdef FP_ADDSUB_ROUND_EN
      guard_q      <= guard_d;
`endif
    end
  end

  assign busy = (state_q == S_ALIGN) || (state_q == S_ADDSUB) || (state_q == S_NORM)
`ifdef FP_ADDSUB_ROUND_EN
             || (state_q == S_ROUND)
`endif
             ;
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: integer reference model plus per-cycle output compare.
// Directed cases from the reference examples, then randomized operations with ignored start noise.
// Ends with a reset asserted mid-operation.
`timescale 1ns/1ps
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [10:0] a, b;
  logic        busy, done, overflow, underflow;
  logic [10:0] result;

  always #5 clk = ~clk;

  fp_addsub_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .underflow(underflow)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_done, exp_ovf, exp_unf;
  logic [10:0] exp_res;
  string       tag = "reset";

  // Reference: value = mant/32 * 2^(exp-8), evaluated with plain integers.
  function automatic void model(input logic [10:0] fa, input logic [10:0] fb, input logic fop,
                                output logic [10:0] fr, output logic fo, output logic fu,
                                output int lat);
    int sa, sb, bs, ss, be, bm, sm, d, g, sum, e, s, n;
    bit fin;
    sa = int'(fa[10]);
    sb = int'(fb[10] ^ fop);
    if (fa[9:0] >= fb[9:0]) begin
      bs = sa; ss = sb; be = int'(fa[9:6]); bm = int'(fa[5:0]); sm = int'(fb[5:0]);
      d = int'(fa[9:6]) - int'(fb[9:6]);
    end else begin
      bs = sb; ss = sa; be = int'(fb[9:6]); bm = int'(fb[5:0]); sm = int'(fa[5:0]);
      d = int'(fb[9:6]) - int'(fa[9:6]);
    end
    if (d > 6) d = 6;
    g   = (d > 0) ? ((sm >> (d - 1)) & 1) : 0;
    sm  = sm >> d;
    sum = (bs == ss) ? bm + sm : bm - sm;
    e = be; s = bs; n = 0; fo = 1'b0; fu = 1'b0; fin = 1'b0;
    for (int it = 0; it < 16 && !fin; it++) begin
      if (sum >= 64) begin
        if (e == 15) begin fo = 1'b1; sum = 63; fin = 1'b1; end
        else begin g = sum & 1; sum = sum / 2; e++; n++; end
      end else if (sum == 0) begin
        s = 0; e = 0; fin = 1'b1;
      end else if (sum < 32) begin
        if (e == 0) begin fu = 1'b1; s = 0; sum = 0; fin = 1'b1; end
        else begin sum = sum * 2; e--; n++; end
      end else begin
        fin = 1'b1;
      end
    end
    lat = 3 + d + n;
`ifdef FP_ADDSUB_ROUND_EN
    lat++;
    if (!fo && !fu && sum != 0 && g == 1) begin
      sum++;
      if (sum == 64) begin
        if (e == 15) begin fo = 1'b1; sum = 63; end
        else begin sum = 32; e++; end
      end
    end
`else
    if (g > 1) lat = -1;
`endif
    fr = {1'(s), 4'(e), 6'(sum)};
  endfunction

  // Per-cycle compare of every output against the current expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (busy !== exp_busy || done !== exp_done || result !== exp_res ||
          overflow !== exp_ovf || underflow !== exp_unf) begin
        n_err++;
        $display("FAIL %s t=%0t got busy=%b done=%b result=%b ovf=%b unf=%b want busy=%b done=%b result=%b ovf=%b unf=%b",
                 tag, $time, busy, done, result, overflow, underflow,
                 exp_busy, exp_done, exp_res, exp_ovf, exp_unf);
      end
    end
  end

  task automatic pin(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL model_%s got %0d want %0d", name, got, want);
    end
  endtask

  // Issue one operation; caller is at #1 after an edge with the DUT in IDLE or DONE.
  task automatic run_op(input logic [10:0] ta, input logic [10:0] tb, input logic top,
                        input bit noisy, input string name);
    logic [10:0] r;
    logic        o, u;
    int          lat;
    model(ta, tb, top, r, o, u, lat);
    tag = name; a = ta; b = tb; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1; exp_done = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (noisy) begin
        start = 1'($urandom); a = 11'($urandom); b = 11'($urandom); op = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b1; exp_res = r; exp_ovf = o; exp_unf = u;
  endtask

  task automatic go_idle(input int gap);
    @(posedge clk); #1;
    exp_done = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  function automatic logic [10:0] rnd_val(input int e);
    if ($urandom_range(0, 9) == 0) return {1'($urandom), 10'd0};
    return {1'($urandom), 4'(e), 1'b1, 5'($urandom)};
  endfunction

  logic [10:0] pr;
  logic        po, pu;
  int          pl;
  int          ea, eb;
  logic [10:0] ra, rb;
  logic [10:0] res_before;

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 11'd0; b = 11'd0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_res = 11'd0; exp_ovf = 1'b0; exp_unf = 1'b0;

    // Hand-computed expectations that pin the reference model.
    model(11'b0_1000_100000, 11'b0_1000_100000, 1'b0, pr, po, pu, pl);
    pin("add_res", int'(pr), int'(11'b0_1001_100000));
`ifdef FP_ADDSUB_ROUND_EN
    pin("add_lat", pl, 5);
`else
    pin("add_lat", pl, 4);
`endif
    model(11'b0_1000_100000, 11'b0_1000_100000, 1'b1, pr, po, pu, pl);
    pin("sub_res", int'(pr), 0);
`ifndef FP_ADDSUB_ROUND_EN
    pin("sub_lat", pl, 3);
`endif
    model(11'b0_1000_100000, 11'b0_0000_100000, 1'b0, pr, po, pu, pl);
`ifndef FP_ADDSUB_ROUND_EN
    pin("far_res", int'(pr), int'(11'b0_1000_100000));
    pin("far_lat", pl, 9);
`endif
    model(11'b0_1111_111111, 11'b0_1111_111111, 1'b0, pr, po, pu, pl);
    pin("ovf_res", int'(pr), int'(11'b0_1111_111111));
    pin("ovf_flag", int'(po), 1);
    pin("ovf_unf", int'(pu), 0);
    model(11'b0_1000_100000, 11'b0_0111_100001, 1'b0, pr, po, pu, pl);
`ifdef FP_ADDSUB_ROUND_EN
    pin("rnd_res", int'(pr), int'(11'b0_1000_110001));
`else
    pin("rnd_res", int'(pr), int'(11'b0_1000_110000));
`endif
    model(11'b0_0000_100001, 11'b0_0000_100000, 1'b1, pr, po, pu, pl);
    pin("unf_flag", int'(pu), 1);

    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_op(11'b0_1000_100000, 11'b0_1000_100000, 1'b0, 1'b0, "add_equal");      go_idle(1);
    run_op(11'b0_1000_100000, 11'b0_1000_100000, 1'b1, 1'b0, "sub_cancel");     go_idle(1);
    run_op(11'b0_1000_100000, 11'b0_0000_100000, 1'b0, 1'b0, "align_max");      go_idle(1);
    run_op(11'b0_1111_111111, 11'b0_1111_111111, 1'b0, 1'b0, "overflow");       go_idle(1);
    run_op(11'b0_1000_100000, 11'b0_0111_100001, 1'b0, 1'b0, "guard_case");     go_idle(1);
    run_op(11'b0_0000_100001, 11'b0_0000_100000, 1'b1, 1'b0, "underflow");      go_idle(0);
    run_op(11'b1_0101_110011, 11'b0_0110_101010, 1'b1, 1'b1, "neg_noisy");
    run_op(11'b0_0011_111000, 11'b0_0011_100111, 1'b1, 1'b1, "chained_sub");    go_idle(2);

    for (int i = 0; i < 400; i++) begin
      ea = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: eb = $urandom_range(0, 15);
        1: eb = ea;
        2: begin ea = $urandom_range(0, 2); eb = $urandom_range(0, 2); end
        default: begin ea = 15; eb = $urandom_range(13, 15); end
      endcase
      ra = rnd_val(ea);
      rb = rnd_val(eb);
      run_op(ra, rb, 1'($urandom), 1'($urandom), "random");
      if ($urandom_range(0, 3) != 0) go_idle($urandom_range(0, 2));
    end
    go_idle(1);

    // Ignored start while busy, then reset asserted while in NORM.
    run_op(11'b0_1010_101010, 11'b0_1010_100000, 1'b0, 1'b0, "pre_reset"); go_idle(1);
    res_before = exp_res;
    tag = "busy_start"; a = 11'b0_1000_100000; b = 11'b0_1000_100000; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;                                   // edge 0: ALIGN
    exp_busy = 1'b1; exp_ovf = 1'b0; exp_unf = 1'b0; exp_res = res_before;
    a = 11'b1_1111_111111; b = 11'b1_1111_111111;           // still high: ignored in ALIGN
    @(posedge clk); #1; start = 1'b0;                     // edge 1: ADDSUB
    @(posedge clk); #1;                                   // edge 2: NORM
    tag = "mid_reset";
    @(posedge clk); #1;                                   // edge 3: still NORM
    reset = 1'b1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_res = 11'd0; exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    tag = "post_reset_idle";
    repeat (8) begin @(posedge clk); #1; end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
